icache_set_assoc: RTL
=====================

// Module: icache_set_assoc
// PURPOSE
//  N-way set-associative, multi-word-line instruction cache between the instruction fetcher (IF) and the memory controller (MC).
//  One outstanding miss, 1-cycle hit latency, tree-PLRU replacement, full invalidate (fence.i) and IF-side request cancel (mispredict).
// PARAMETERS
//  ADDR_WIDTH   32  byte-address width
//  BLOCK_WIDTH  2   log2(words per line); BLOCK_SIZE = 1<<BLOCK_WIDTH
//  CACHE_WIDTH  6   log2(sets); SET_NUM = 1<<CACHE_WIDTH
//  WAY_WIDTH    1   log2(ways); WAY_NUM = 1<<WAY_WIDTH
// PORTS
//  Sys_clk     in   1              clock
//  Sys_rst     in   1              synchronous active-high reset
//  Sys_rdy     in   1              global enable; 0 = freeze
//  IFIC_en     in   1              fetch request; IF holds addr until ICIF_en
//  IFIC_addr   in   ADDR_WIDTH     fetch byte address, [1:0]=00
//  IFIC_clear  in   1              cancel current/pending fetch
//  IC_flush    in   1              invalidate all lines
//  ICIF_en     out  1              response valid, 1-cycle pulse
//  ICIF_data   out  32             instruction word
//  ICMC_en     out  1              line-fill request, level until MCIC_en
//  ICMC_addr   out  ADDR_WIDTH     line-aligned fill address
//  MCIC_en     in   1              fill data valid, 1 cycle
//  MCIC_block  in   32*BLOCK_SIZE  line; word j = bits [32j+31:32j]
//  (ICACHE_PERF_CNT_EN) IC_hit_cnt, IC_miss_cnt  out 32 each
// BEHAVIOUR
//  Addr split: offset [BLOCK_WIDTH+1:2], index [BLOCK_WIDTH+CACHE_WIDTH+1:BLOCK_WIDTH+2], tag = rest.
//  Reset: state IDLE; all valid/PLRU bits 0; ICIF_en, ICIF_data, ICMC_en, ICMC_addr, counters 0. Reset mid-miss abandons fill.
//  Sys_rdy=0: no register changes; all outputs hold.
//  ICIF_en is high for exactly one cycle per response; cleared next cycle unless a new response issues.
//  IDLE, IFIC_en=1, no clear/flush: parallel tag compare over all ways of the set.
//   hit -> next cycle ICIF_en=1, ICIF_data=word[offset]; PLRU touch hit way.
//   miss -> latch addr; next cycle ICMC_en=1, ICMC_addr = addr with low BLOCK_WIDTH+2 bits zeroed; go MISS.
//  MISS: IFIC_en ignored. On MCIC_en: victim = lowest-index invalid way, else PLRU victim; write line, tag, valid=1; PLRU touch;
//   ICMC_en=0; ICIF_en=1, ICIF_data = MCIC_block word at LATCHED offset; go IDLE. Hit-under-miss not supported.
//  IFIC_clear: IDLE -> same-cycle request dropped. MISS -> cancel flag set; fill still written, ICIF_en stays 0 on MCIC_en.
//   Clear in same cycle as MCIC_en -> line written, response suppressed.
//  IC_flush: all valid bits 0 at next edge; same-cycle IDLE request dropped (IF re-presents).
//   Flush during MISS: fill completes and responds, but line NOT marked valid. Flush same cycle as MCIC_en: same.
//  MCIC_en while IDLE: ignored.
//  PLRU: tree of WAY_NUM-1 bits per set; touch points bits away from accessed way; WAY_WIDTH=0 -> direct-mapped, no PLRU.
// CONFIGURATION
//  ICACHE_PERF_CNT_EN defined: ports IC_hit_cnt/IC_miss_cnt exist; +1 per hit / per miss issued (cleared requests not counted),
//   wrap at 2^32, frozen when Sys_rdy=0, reset 0. Undefined: ports and logic absent, behaviour otherwise identical.
// STRUCTURE
//  Package icache_pkg: OFFSET_W/INDEX_W/TAG_W derivation, state enum {IDLE, MISS}, addr-field extract functions.
//  Sub-module icache_plru: per-set PLRU storage; inputs set index, touch_en, touch_way; output victim_way.
//  Data/tag/valid arrays stay in top.
// TESTING (defaults: 16B lines, 64 sets, 2 ways; 0x1000/0x1400/0x1800 map to set 0)
//  1 fetch 0x1004 after reset -> ICMC_en=1, ICMC_addr=0x1000; MCIC_block words{3..0}={D,C,B,A} -> ICIF_en 1 cycle, data=B;
//    fetch 0x1008 -> hit next cycle, data=C, ICMC_en stays 0.
//  2 fill 0x1000, fill 0x1400, hit 0x1000, fetch 0x1800 -> evicts 0x1400; then 0x1000 hit, 0x1400 miss.
//  3 after test 1, IC_flush 1 cycle, fetch 0x1000 -> miss; flush during that miss -> response given, refetch misses again.
//  4 fetch 0x2000 (miss), IFIC_clear 2 cycles later, MCIC_en 3 cycles later -> no ICIF_en, state IDLE; fetch 0x2000 -> hit.
//  5 Sys_rdy=0 for 3 cycles during MISS with MCIC_en pulses -> nothing changes; after Sys_rdy=1 fill accepted normally.
//  6 ICACHE_PERF_CNT_EN: after test 1 -> IC_hit_cnt=1, IC_miss_cnt=1; Sys_rst mid-miss -> ICMC_en=0, counters 0.

Source files
------------

// File: rtl/icache_set_assoc_pkg.sv
`default_nettype none
// ============================================================================
// Package  : icache_pkg
// Desc     : Shared types and address-field helpers for the set-associative
//            instruction cache (field widths, FSM state, field extraction).
// Revision : 1.0 - initial release
// ============================================================================
package icache_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_t;

  function automatic int offset_w(input int block_w);
    return block_w;
  endfunction

  function automatic int index_w(input int cache_w);
    return cache_w;
  endfunction

  function automatic int tag_w(input int addr_w, input int block_w, input int cache_w);
    return addr_w - block_w - cache_w - 2;
  endfunction

  // Vector widths must stay >= 1 even when a field collapses to zero bits.
  function automatic int field_w(input int w);
    return (w > 0) ? w : 1;
  endfunction

  function automatic logic [63:0] addr_offset(input logic [63:0] addr, input int block_w);
    return (addr >> 2) & ((64'd1 << block_w) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_index(input logic [63:0] addr, input int block_w,
                                             input int cache_w);
    return (addr >> (block_w + 2)) & ((64'd1 << cache_w) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int block_w,
                                           input int cache_w);
    return addr >> (block_w + cache_w + 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_set_assoc_plru.sv
`default_nettype none
// ============================================================================
// Module   : icache_plru
// Desc     : Per-set tree pseudo-LRU state. Each set holds WAY_NUM-1 tree
//            bits in heap order (node 1 = root); a bit value names the
//            subtree to evict next. A touch points every node on the path
//            away from the accessed way. WAY_WIDTH = 0 degenerates to a
//            direct-mapped cache with no storage.
// Revision : 1.0 - initial release
// ============================================================================
module icache_plru
  import icache_pkg::*;
#(
  parameter int CACHE_WIDTH = 6,
  parameter int WAY_WIDTH   = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [field_w(index_w(CACHE_WIDTH))-1:0] set_index,
  input  logic                                   touch_en,
  input  logic [field_w(WAY_WIDTH)-1:0]           touch_way,
  output logic [field_w(WAY_WIDTH)-1:0]           victim_way
);

  localparam int SET_NUM = 1 << CACHE_WIDTH;
  localparam int WAY_NUM = 1 << WAY_WIDTH;

  generate
    if (WAY_WIDTH == 0) begin : g_direct
      logic unused_plru_inputs;
      assign unused_plru_inputs = ^{clk, rst, set_index, touch_en, touch_way};
      assign victim_way = '0;
    end else begin : g_tree
      // Row is 2*WAY_NUM wide so the heap node index needs no width juggling.
      logic [2*WAY_NUM-1:0] tree [SET_NUM];
      logic [2*WAY_NUM-1:0] next_row;

      // Walk the tree following the stored bits to find the victim way.
      always_comb begin
        logic [WAY_WIDTH:0] node;
        victim_way = '0;
        node       = (WAY_WIDTH + 1)'(1);
        for (int l = WAY_WIDTH - 1; l >= 0; l--) begin
          victim_way[l] = tree[set_index][node];
          node          = {node[WAY_WIDTH-1:0], tree[set_index][node]};
        end
      end

      // Build the updated row that points every path node away from touch_way.
      always_comb begin
        logic [WAY_WIDTH:0] tnode;
        next_row = tree[set_index];
        tnode    = (WAY_WIDTH + 1)'(1);
        for (int l = WAY_WIDTH - 1; l >= 0; l--) begin
          next_row[tnode] = ~touch_way[l];
          tnode           = {tnode[WAY_WIDTH-1:0], touch_way[l]};
        end
      end

      // Tree storage: cleared on reset, updated on touch.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < SET_NUM; s++) tree[s] <= '0;
        end else if (touch_en) begin
          tree[set_index] <= next_row;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/icache_set_assoc.sv
`default_nettype none
// ============================================================================
// Module   : icache_set_assoc
// Desc     : N-way set-associative instruction cache with multi-word lines,
//            one outstanding miss, 1-cycle hit latency, tree-PLRU
//            replacement, full invalidate and fetch cancel.
// Config   : define ICACHE_PERF_CNT_EN to add IC_hit_cnt / IC_miss_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module icache_set_assoc
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 2,
  parameter int CACHE_WIDTH = 6,
  parameter int WAY_WIDTH   = 1
) (
  input  logic                            Sys_clk,
  input  logic                            Sys_rst,
  input  logic                            Sys_rdy,
  input  logic                            IFIC_en,
  input  logic [ADDR_WIDTH-1:0]           IFIC_addr,
  input  logic                            IFIC_clear,
  input  logic                            IC_flush,
  output logic                            ICIF_en,
  output logic [31:0]                     ICIF_data,
  output logic                            ICMC_en,
  output logic [ADDR_WIDTH-1:0]           ICMC_addr,
  input  logic                            MCIC_en,
  input  logic [32*(1<<BLOCK_WIDTH)-1:0]  MCIC_block
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]                     IC_hit_cnt,
  output logic [31:0]                     IC_miss_cnt
`endif
);

  localparam int BLOCK_SIZE = 1 << BLOCK_WIDTH;
  localparam int SET_NUM    = 1 << CACHE_WIDTH;
  localparam int WAY_NUM    = 1 << WAY_WIDTH;
  localparam int OW         = field_w(offset_w(BLOCK_WIDTH));
  localparam int IW         = field_w(index_w(CACHE_WIDTH));
  localparam int TW         = tag_w(ADDR_WIDTH, BLOCK_WIDTH, CACHE_WIDTH);
  localparam int VW         = field_w(WAY_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ADDR_WIDTH'((64'd1 << (BLOCK_WIDTH + 2)) - 64'd1);

  logic [31:0]       data_mem  [SET_NUM][WAY_NUM][BLOCK_SIZE];
  logic [TW-1:0]     tag_mem   [SET_NUM][WAY_NUM];
  logic [WAY_NUM-1:0] valid_mem [SET_NUM];

  state_t                state;
  logic [ADDR_WIDTH-1:0] miss_addr;
  logic                  cancel;     // fetch withdrawn while the fill is in flight
  logic                  no_alloc;   // flush seen while the fill is in flight

  logic [OW-1:0] req_offset, miss_offset;
  logic [IW-1:0] req_index, miss_index, plru_index;
  logic [TW-1:0] req_tag, miss_tag;
  logic [WAY_NUM-1:0] hit_vec;
  logic [VW-1:0] hit_way, inv_way, fill_way, plru_victim, touch_way;
  logic          inv_found, is_hit, req_go, fill_go, touch_en;
  logic [31:0]   hit_data, fill_word;

  assign req_offset  = OW'(addr_offset(64'(IFIC_addr), BLOCK_WIDTH));
  assign req_index   = IW'(addr_index(64'(IFIC_addr), BLOCK_WIDTH, CACHE_WIDTH));
  assign req_tag     = TW'(addr_tag(64'(IFIC_addr), BLOCK_WIDTH, CACHE_WIDTH));
  assign miss_offset = OW'(addr_offset(64'(miss_addr), BLOCK_WIDTH));
  assign miss_index  = IW'(addr_index(64'(miss_addr), BLOCK_WIDTH, CACHE_WIDTH));
  assign miss_tag    = TW'(addr_tag(64'(miss_addr), BLOCK_WIDTH, CACHE_WIDTH));

  // Parallel tag compare over every way of the requested set.
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAY_NUM; w++)
      hit_vec[w] = valid_mem[req_index][w] && (tag_mem[req_index][w] == req_tag);
    for (int w = WAY_NUM - 1; w >= 0; w--)
      if (hit_vec[w]) hit_way = VW'(w);
  end

  // Lowest-index invalid way in the missing set takes priority over PLRU.
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAY_NUM - 1; w >= 0; w--)
      if (!valid_mem[miss_index][w]) begin
        inv_found = 1'b1;
        inv_way   = VW'(w);
      end
  end

  assign is_hit     = |hit_vec;
  assign hit_data   = data_mem[req_index][hit_way][req_offset];
  assign fill_word  = MCIC_block[32*int'(miss_offset) +: 32];
  assign fill_way   = inv_found ? inv_way : plru_victim;
  assign req_go     = (state == IDLE) && IFIC_en && !IFIC_clear && !IC_flush;
  assign fill_go    = (state == MISS) && MCIC_en;
  assign plru_index = (state == MISS) ? miss_index : req_index;
  assign touch_way  = (state == MISS) ? fill_way : hit_way;
  assign touch_en   = !Sys_rst && Sys_rdy && ((req_go && is_hit) || fill_go);

  icache_plru #(
    .CACHE_WIDTH (CACHE_WIDTH),
    .WAY_WIDTH   (WAY_WIDTH)
  ) u_plru (
    .clk        (Sys_clk),
    .rst        (Sys_rst),
    .set_index  (plru_index),
    .touch_en   (touch_en),
    .touch_way  (touch_way),
    .victim_way (plru_victim)
  );

  // Control FSM with registered IF/MC handshake outputs.
  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      state     <= IDLE;
      ICIF_en   <= 1'b0;
      ICIF_data <= '0;
      ICMC_en   <= 1'b0;
      ICMC_addr <= '0;
      miss_addr <= '0;
      cancel    <= 1'b0;
      no_alloc  <= 1'b0;
    end else if (Sys_rdy) begin
      ICIF_en <= 1'b0;
      case (state)
        IDLE: begin
          if (req_go) begin
            if (is_hit) begin
              ICIF_en   <= 1'b1;
              ICIF_data <= hit_data;
            end else begin
              miss_addr <= IFIC_addr;
              ICMC_en   <= 1'b1;
              ICMC_addr <= IFIC_addr & ~LINE_MASK;
              cancel    <= 1'b0;
              no_alloc  <= 1'b0;
              state     <= MISS;
            end
          end
        end
        MISS: begin
          if (fill_go) begin
            ICMC_en <= 1'b0;
            state   <= IDLE;
            if (!(cancel || IFIC_clear)) begin
              ICIF_en   <= 1'b1;
              ICIF_data <= fill_word;
            end
          end else begin
            if (IFIC_clear) cancel   <= 1'b1;
            if (IC_flush)   no_alloc <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Valid bits: flush wins over a concurrent fill so the line stays invalid.
  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      for (int s = 0; s < SET_NUM; s++) valid_mem[s] <= '0;
    end else if (Sys_rdy) begin
      if (IC_flush) begin
        for (int s = 0; s < SET_NUM; s++) valid_mem[s] <= '0;
      end else if (fill_go && !no_alloc) begin
        valid_mem[miss_index][fill_way] <= 1'b1;
      end
    end
  end

  // Line data and tag write on fill; contents are meaningless until valid.
  always_ff @(posedge Sys_clk) begin
    if (!Sys_rst && Sys_rdy && fill_go) begin
      tag_mem[miss_index][fill_way] <= miss_tag;
      for (int j = 0; j < BLOCK_SIZE; j++)
        data_mem[miss_index][fill_way][j] <= MCIC_block[32*j +: 32];
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  // Hit / miss event counters, free-running with natural wrap.
  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      IC_hit_cnt  <= '0;
      IC_miss_cnt <= '0;
    end else if (Sys_rdy && req_go) begin
      if (is_hit) IC_hit_cnt  <= IC_hit_cnt + 32'd1;
      else        IC_miss_cnt <= IC_miss_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire
